mem_bus_arbiter: RTL and testbench

Arbitrates the shared peripheral bus between two masters: the pipeline M-stage peripheral path (m_sel/m_rnw/m_addr/m_data) and a debug/loader master.
- Drives a single request/ready bus toward peripherals.
- Returns read data to the winning master.
- Generates the stall that freezes the pipeline while a core access is outstanding.
- Sits between the datapath M-stage bus outputs and the peripheral interconnect.

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, its two masters (M-stage core path and
// debug/loader) and the shared peripheral bus. The arbiter uses the slave
// modport; the surrounding environment uses the master modport.
interface mem_bus_arbiter_if;
  // core (M-stage) side
  logic        core_req;
  logic        core_rnw;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  // debug/loader side
  logic        dbg_req;
  logic        dbg_rnw;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  // peripheral bus side
  logic        bus_valid;
  logic        bus_rnw;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;

  modport master (
    output core_req, core_rnw, core_addr, core_wdata,
    output dbg_req, dbg_rnw, dbg_addr, dbg_wdata,
    output bus_rdata, bus_ready,
    input  core_rdata, core_stall, dbg_rdata, dbg_ack,
    input  bus_valid, bus_rnw, bus_addr, bus_wdata, bus_err
  );

  modport slave (
    input  core_req, core_rnw, core_addr, core_wdata,
    input  dbg_req, dbg_rnw, dbg_addr, dbg_wdata,
    input  bus_rdata, bus_ready,
    output core_rdata, core_stall, dbg_rdata, dbg_ack,
    output bus_valid, bus_rnw, bus_addr, bus_wdata, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared peripheral bus (core M-stage path and
// debug/loader). Core normally wins, but after MAX_CORE_BURST consecutive core
// grants with debug waiting, debug is forced through. Core accesses stall the
// pipeline until the CORE_DONE cycle.
// Optional macro BUS_TIMEOUT_EN: abort transfers after TIMEOUT cycles without
// bus_ready, returning 32'hDEAD_BEEF and setting sticky bus_err.
module mem_bus_arbiter #(
  parameter int MAX_CORE_BURST = 4,
  parameter int TIMEOUT        = 64
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.slave  io
);

  localparam int FW = $clog2(MAX_CORE_BURST + 1);
  localparam logic [FW-1:0] FAIR_MAX = FW'(MAX_CORE_BURST);

  typedef enum logic [2:0] {
    IDLE,
    CORE_XFER,
    CORE_DONE,
    DBG_XFER,
    DBG_DONE
  } state_t;

  state_t        state_reg;
  logic [FW-1:0] fair_cnt_reg;
  logic          bus_valid_reg;
  logic          bus_rnw_reg;
  logic [31:0]   bus_addr_reg;
  logic [31:0]   bus_wdata_reg;
  logic [31:0]   core_rdata_reg;
  logic [31:0]   dbg_rdata_reg;
  logic          dbg_ack_reg;
  logic          core_win;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_reg;
  logic          bus_err_reg;
  assign io.bus_err = bus_err_reg;
`else
  assign io.bus_err = 1'b0;
`endif

  // Core wins unless debug is waiting and the core has used its burst allowance
  assign core_win = io.core_req && (!io.dbg_req || (fair_cnt_reg < FAIR_MAX));

  // Pipeline freezes while a core access is pending; it advances out of CORE_DONE
  assign io.core_stall = io.core_req & (state_reg != CORE_DONE);

  assign io.bus_valid  = bus_valid_reg;
  assign io.bus_rnw    = bus_rnw_reg;
  assign io.bus_addr   = bus_addr_reg;
  assign io.bus_wdata  = bus_wdata_reg;
  assign io.core_rdata = core_rdata_reg;
  assign io.dbg_rdata  = dbg_rdata_reg;
  assign io.dbg_ack    = dbg_ack_reg;

  // Arbitration FSM with registered bus, read-data and ack outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fair_cnt_reg   <= '0;
      bus_valid_reg  <= 1'b0;
      bus_rnw_reg    <= 1'b0;
      bus_addr_reg   <= '0;
      bus_wdata_reg  <= '0;
      core_rdata_reg <= '0;
      dbg_rdata_reg  <= '0;
      dbg_ack_reg    <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      bus_err_reg    <= 1'b0;
`endif
    end else begin
      dbg_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
`ifdef BUS_TIMEOUT_EN
          tmo_cnt_reg <= '0;
`endif
          if (!io.dbg_req) fair_cnt_reg <= '0;
          if (core_win) begin
            bus_valid_reg <= 1'b1;
            bus_rnw_reg   <= io.core_rnw;
            bus_addr_reg  <= io.core_addr;
            bus_wdata_reg <= io.core_wdata;
            state_reg     <= CORE_XFER;
            // core_win with dbg_req implies the count is below the limit
            if (io.dbg_req) fair_cnt_reg <= fair_cnt_reg + 1'b1;
          end else if (io.dbg_req) begin
            bus_valid_reg <= 1'b1;
            bus_rnw_reg   <= io.dbg_rnw;
            bus_addr_reg  <= io.dbg_addr;
            bus_wdata_reg <= io.dbg_wdata;
            fair_cnt_reg  <= '0;
            state_reg     <= DBG_XFER;
          end
        end
        CORE_XFER, DBG_XFER: begin
          if (io.bus_ready) begin
            bus_valid_reg <= 1'b0;
            if (state_reg == CORE_XFER) begin
              if (bus_rnw_reg) core_rdata_reg <= io.bus_rdata;
              state_reg <= CORE_DONE;
            end else begin
              if (bus_rnw_reg) dbg_rdata_reg <= io.bus_rdata;
              dbg_ack_reg <= 1'b1;
              state_reg   <= DBG_DONE;
            end
          end
`ifdef BUS_TIMEOUT_EN
          // Slave never answered: finish with a poison value and flag it
          else if (tmo_cnt_reg == TMO_LAST) begin
            bus_valid_reg <= 1'b0;
            bus_err_reg   <= 1'b1;
            if (state_reg == CORE_XFER) begin
              if (bus_rnw_reg) core_rdata_reg <= 32'hDEAD_BEEF;
              state_reg <= CORE_DONE;
            end else begin
              if (bus_rnw_reg) dbg_rdata_reg <= 32'hDEAD_BEEF;
              dbg_ack_reg <= 1'b1;
              state_reg   <= DBG_DONE;
            end
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        CORE_DONE: state_reg <= IDLE;
        DBG_DONE:  state_reg <= IDLE;
        default:   state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: core read/write, debug read, async reset
// mid-transfer, core/debug fairness and (with BUS_TIMEOUT_EN) bus timeout.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  mem_bus_arbiter_if io_if ();

  mem_bus_arbiter #(
    .MAX_CORE_BURST (4),
    .TIMEOUT        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // grant monitor, active only during the fairness test
  logic        mon_en;
  logic        prev_valid;
  logic [31:0] grant_q[$];
  int          ack_cnt;

  initial begin
    prev_valid = 1'b0;
    ack_cnt    = 0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (io_if.bus_valid && !prev_valid) grant_q.push_back(io_if.bus_addr);
      if (io_if.dbg_ack) ack_cnt++;
    end
    prev_valid = io_if.bus_valid;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    io_if.core_req = 0; io_if.core_rnw = 0; io_if.core_addr = '0; io_if.core_wdata = '0;
    io_if.dbg_req = 0;  io_if.dbg_rnw = 0;  io_if.dbg_addr = '0;  io_if.dbg_wdata = '0;
    io_if.bus_rdata = '0; io_if.bus_ready = 0;

    // ---- reset state
    #12;
    check_vec("rst_bus_valid", {31'd0, io_if.bus_valid}, 32'd0);
    check_vec("rst_core_rdata", io_if.core_rdata, 32'd0);
    check_vec("rst_dbg_ack", {31'd0, io_if.dbg_ack}, 32'd0);
    check_vec("rst_bus_err", {31'd0, io_if.bus_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    $display("txn reset: done");

    // ---- core read, ready in the first XFER cycle
    io_if.core_req = 1; io_if.core_rnw = 1; io_if.core_addr = 32'h8000_0010;
    sample();
    check_vec("rd_c0_stall", {31'd0, io_if.core_stall}, 32'd1);
    check_vec("rd_c0_valid", {31'd0, io_if.bus_valid}, 32'd0);
    tick();
    io_if.bus_ready = 1; io_if.bus_rdata = 32'h1234_5678;
    sample();
    check_vec("rd_c1_valid", {31'd0, io_if.bus_valid}, 32'd1);
    check_vec("rd_c1_addr", io_if.bus_addr, 32'h8000_0010);
    check_vec("rd_c1_rnw", {31'd0, io_if.bus_rnw}, 32'd1);
    check_vec("rd_c1_stall", {31'd0, io_if.core_stall}, 32'd1);
    tick();
    io_if.bus_ready = 0; io_if.bus_rdata = 32'h0;
    sample();
    check_vec("rd_c2_stall", {31'd0, io_if.core_stall}, 32'd0);
    check_vec("rd_c2_valid", {31'd0, io_if.bus_valid}, 32'd0);
    check_vec("rd_c2_rdata", io_if.core_rdata, 32'h1234_5678);
    tick();
    io_if.core_req = 0;
    $display("txn core_read addr=80000010 done");

    // ---- core write, ready after 5 waiting XFER cycles; inputs change mid-transfer
    io_if.core_req = 1; io_if.core_rnw = 0; io_if.core_addr = 32'h8000_0004;
    io_if.core_wdata = 32'hA5A5_A5A5;
    tick();
    io_if.core_addr = 32'h0000_0BAD; io_if.core_wdata = 32'h1111_1111; io_if.core_rnw = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      check_vec($sformatf("wr_addr_%0d", i), io_if.bus_addr, 32'h8000_0004);
      check_vec($sformatf("wr_data_%0d", i), io_if.bus_wdata, 32'hA5A5_A5A5);
      check_vec($sformatf("wr_rnw_%0d", i), {31'd0, io_if.bus_rnw}, 32'd0);
      check_vec($sformatf("wr_stall_%0d", i), {31'd0, io_if.core_stall}, 32'd1);
      tick();
    end
    io_if.bus_ready = 1; io_if.bus_rdata = 32'h7777_7777;
    sample();
    check_vec("wr_last_valid", {31'd0, io_if.bus_valid}, 32'd1);
    tick();
    io_if.bus_ready = 0;
    sample();
    check_vec("wr_done_stall", {31'd0, io_if.core_stall}, 32'd0);
    check_vec("wr_done_rdata", io_if.core_rdata, 32'h1234_5678);
    tick();
    io_if.core_req = 0;
    $display("txn core_write addr=80000004 done");

    // ---- debug read while idle
    io_if.dbg_req = 1; io_if.dbg_rnw = 1; io_if.dbg_addr = 32'h4000_0000;
    tick();
    io_if.bus_ready = 1; io_if.bus_rdata = 32'hCAFE_0001;
    sample();
    check_vec("dbg_xfer_addr", io_if.bus_addr, 32'h4000_0000);
    check_vec("dbg_xfer_ack", {31'd0, io_if.dbg_ack}, 32'd0);
    tick();
    io_if.bus_ready = 0; io_if.dbg_req = 0;
    sample();
    check_vec("dbg_done_ack", {31'd0, io_if.dbg_ack}, 32'd1);
    check_vec("dbg_done_rdata", io_if.dbg_rdata, 32'hCAFE_0001);
    check_vec("dbg_core_stall", {31'd0, io_if.core_stall}, 32'd0);
    tick();
    sample();
    check_vec("dbg_ack_drop", {31'd0, io_if.dbg_ack}, 32'd0);
    check_vec("dbg_idle_valid", {31'd0, io_if.bus_valid}, 32'd0);
    tick();
    $display("txn dbg_read addr=40000000 done");

    // ---- async reset during CORE_XFER
    io_if.core_req = 1; io_if.core_rnw = 1; io_if.core_addr = 32'h8000_0020;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_vec("arst_valid", {31'd0, io_if.bus_valid}, 32'd0);
    check_vec("arst_addr", io_if.bus_addr, 32'd0);
    check_vec("arst_rdata", io_if.core_rdata, 32'd0);
    check_vec("arst_dbg_rdata", io_if.dbg_rdata, 32'd0);
    io_if.core_req = 0;
    tick();
    check_vec("arst_ack", {31'd0, io_if.dbg_ack}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    io_if.core_req = 1; io_if.core_rnw = 1; io_if.core_addr = 32'h8000_0030;
    tick();
    io_if.bus_ready = 1; io_if.bus_rdata = 32'h0BAD_F00D;
    sample();
    check_vec("post_rst_valid", {31'd0, io_if.bus_valid}, 32'd1);
    check_vec("post_rst_addr", io_if.bus_addr, 32'h8000_0030);
    tick();
    io_if.bus_ready = 0;
    sample();
    check_vec("post_rst_rdata", io_if.core_rdata, 32'h0BAD_F00D);
    check_vec("post_rst_stall", {31'd0, io_if.core_stall}, 32'd0);
    tick();
    io_if.core_req = 0;
    tick();
    $display("txn reset_mid_xfer done");

    // ---- fairness: both masters requesting, ready held high
    mon_en = 1'b1;
    io_if.bus_ready = 1; io_if.bus_rdata = 32'h5555_0000;
    io_if.core_req = 1; io_if.core_rnw = 1; io_if.core_addr = 32'h0000_0100;
    io_if.dbg_req = 1;  io_if.dbg_rnw = 1;  io_if.dbg_addr = 32'h0000_0200;
    for (int i = 0; i < 20; i++) tick();
    io_if.core_req = 0; io_if.dbg_req = 0;
    for (int i = 0; i < 4; i++) tick();
    io_if.bus_ready = 0;
    mon_en = 1'b0;
    begin
      logic [31:0] exp_grant[6];
      exp_grant = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h100};
      check_vec("fair_grant_cnt", grant_q.size(), 32'd7);
      for (int i = 0; i < 6; i++) begin
        if (i < grant_q.size())
          check_vec($sformatf("fair_grant_%0d", i), grant_q[i], exp_grant[i]);
      end
      check_vec("fair_ack_cnt", ack_cnt, 32'd1);
    end
    $display("txn fairness: %0d grants observed", grant_q.size());

`ifdef BUS_TIMEOUT_EN
    // ---- timeout: core read with no bus_ready
    io_if.core_req = 1; io_if.core_rnw = 1; io_if.core_addr = 32'h8000_0040;
    tick();
    for (int i = 0; i < 8; i++) begin
      sample();
      check_vec($sformatf("tmo_valid_%0d", i), {31'd0, io_if.bus_valid}, 32'd1);
      tick();
    end
    sample();
    check_vec("tmo_done_valid", {31'd0, io_if.bus_valid}, 32'd0);
    check_vec("tmo_done_stall", {31'd0, io_if.core_stall}, 32'd0);
    check_vec("tmo_rdata", io_if.core_rdata, 32'hDEAD_BEEF);
    check_vec("tmo_err", {31'd0, io_if.bus_err}, 32'd1);
    tick();
    io_if.core_req = 0;
    tick(); tick();
    check_vec("tmo_err_sticky", {31'd0, io_if.bus_err}, 32'd1);
    $display("txn timeout done");
`else
    check_vec("no_tmo_err", {31'd0, io_if.bus_err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
